// File: rtl/hpdcache_prio_arb_hold.sv
// Fixed-priority N-way arbiter (lowest index wins) that holds its grant while downstream stalls.
// Optional anti-starvation aging is compiled in with `define HPDCACHE_PRIO_ARB_AGING_EN.
module hpdcache_prio_arb_hold #(
   parameter  int unsigned N     = 4,
   parameter  int unsigned AGE_W = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N-1:0]     req_i,
   input  logic             ready_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             valid_o
);

   function automatic logic [N-1:0] prio_1hot(input logic [N-1:0] v);
      logic [N-1:0] res;
      logic         found;
      res   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (v[i] && !found) begin
            res[i] = 1'b1;
            found  = 1'b1;
         end
      end
      return res;
   endfunction

   if (N < 1 || AGE_W < 1) begin : g_param_check
      $error("hpdcache_prio_arb_hold: N and AGE_W must be >= 1");
   end

   logic         lock_q, lock_d;
   logic [N-1:0] gnt_q, gnt_d;
   logic [N-1:0] fresh;
   logic         hold;
   logic         xfer;

`ifdef HPDCACHE_PRIO_ARB_AGING_EN
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   logic [AGE_W-1:0] age_q [N];
   logic [AGE_W-1:0] age_d [N];
   logic [N-1:0]     starved;

   always_comb begin
      starved = '0;
      for (int unsigned i = 0; i < N; i++) begin
         starved[i] = req_i[i] && (age_q[i] == AGE_MAX);
      end
      fresh = (|starved) ? prio_1hot(starved) : prio_1hot(req_i);
   end

   // Age only accumulates on cycles where some other requester actually transferred.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         age_d[i] = age_q[i];
         if (!req_i[i]) begin
            age_d[i] = '0;
         end else if (xfer) begin
            if (gnt_o[i]) begin
               age_d[i] = '0;
            end else if (age_q[i] != AGE_MAX) begin
               age_d[i] = age_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < N; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end
`else
   always_comb begin
      fresh = prio_1hot(req_i);
   end
`endif

   always_comb begin
      hold    = lock_q && |(gnt_q & req_i);
      gnt_o   = hold ? gnt_q : fresh;
      valid_o = |gnt_o;
      xfer    = valid_o && ready_i;
      lock_d  = valid_o && !ready_i;
      gnt_d   = lock_d ? gnt_o : '0;
   end

   if (N == 1) begin : g_idx_single
      assign gnt_idx_o = '0;
   end else begin : g_idx_enc
      always_comb begin
         gnt_idx_o = '0;
         for (int unsigned i = 0; i < N; i++) begin
            if (gnt_o[i]) begin
               gnt_idx_o = gnt_idx_o | IDX_W'(i);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q <= 1'b0;
         gnt_q  <= '0;
      end else begin
         lock_q <= lock_d;
         gnt_q  <= gnt_d;
      end
   end

endmodule

// File: tb/tb_hpdcache_prio_arb_hold.sv
// Directed self-checking bench for hpdcache_prio_arb_hold with N=4, AGE_W=2.
module tb_hpdcache_prio_arb_hold;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       ready;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       valid;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   hpdcache_prio_arb_hold #(
      .N     (4),
      .AGE_W (2)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_i     (req),
      .ready_i   (ready),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .valid_o   (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] ei, input logic ev);
      check_eq({tag, ".gnt"}, 32'(gnt), 32'(eg));
      check_eq({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
      check_eq({tag, ".valid"}, 32'(valid), 32'(ev));
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are checked 2 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] age_exp [5];
      rst_n = 1'b0;
      req   = 4'b1010;
      ready = 1'b0;
      #3;
      check_out("rst", 4'b0010, 2'd1, 1'b1);
      check_eq("rst.lock", 32'(dut.lock_q), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      #2;
      check_out("post_rst", 4'b0010, 2'd1, 1'b1);

      // Hold under stall against a higher-priority newcomer
      next_cycle();
      req = 4'b0100; ready = 1'b0;
      #2 check_out("hold.first", 4'b0100, 2'd2, 1'b1);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         req = 4'b0101; ready = 1'b0;
         #2 check_out($sformatf("hold.stall%0d", k), 4'b0100, 2'd2, 1'b1);
      end
      next_cycle();
      ready = 1'b1;
      #2 check_out("hold.xfer", 4'b0100, 2'd2, 1'b1);
      next_cycle();
      req = 4'b0001;
      #2 check_out("hold.after", 4'b0001, 2'd0, 1'b1);
      check_eq("hold.lock_clr", 32'(dut.lock_q), 32'd0);

      // Lock release when the locked requester drops
      next_cycle();
      req = 4'b0100; ready = 1'b0;
      #2 check_out("drop.lock", 4'b0100, 2'd2, 1'b1);
      next_cycle();
      req = 4'b0011;
      #2 check_out("drop.fresh", 4'b0001, 2'd0, 1'b1);

      // Idle
      next_cycle();
      req = 4'b0000; ready = 1'b0;
      #2 check_out("idle0", 4'b0000, 2'd0, 1'b0);
      next_cycle();
      check_eq("idle.lock", 32'(dut.lock_q), 32'd0);
      check_out("idle1", 4'b0000, 2'd0, 1'b0);

      // Higher-priority arrival in the same cycle as the locked transfer
      next_cycle();
      req = 4'b0100; ready = 1'b0;
      #2 check_out("simul.lock", 4'b0100, 2'd2, 1'b1);
      next_cycle();
      req = 4'b0101; ready = 1'b1;
      #2 check_out("simul.xfer", 4'b0100, 2'd2, 1'b1);
      next_cycle();
      #2 check_out("simul.next", 4'b0001, 2'd0, 1'b1);

      // Asynchronous reset while locked
      next_cycle();
      req = 4'b1000; ready = 1'b0;
      #2 check_out("arst.lock", 4'b1000, 2'd3, 1'b1);
      next_cycle();
      req = 4'b1001;
      #1 check_out("arst.held", 4'b1000, 2'd3, 1'b1);
      rst_n = 1'b0;
      #1 check_out("arst.async", 4'b0001, 2'd0, 1'b1);
      check_eq("arst.lock", 32'(dut.lock_q), 32'd0);
      #1 rst_n = 1'b1;

      // Aging with constant ready
      next_cycle();
`ifdef HPDCACHE_PRIO_ARB_AGING_EN
      age_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
`else
      age_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      req = 4'b0011; ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #2 check_out($sformatf("age%0d", k), age_exp[k], (age_exp[k] == 4'b0010) ? 2'd1 : 2'd0, 1'b1);
         next_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, expected completion before 100000");
      $fatal(1, "timeout");
   end

endmodule
